regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: A (ALU, primary) and B (multi-cycle unit, e.g. load/mult).
- Keeps a 32-entry pending-write scoreboard so decode can stall on RAW hazards against rr1/rr2.
- Sits between the execute/writeback units and the register file; drives its regWrite/writeReg/writeData inputs.

Parameters:
- STARVE_MAX, 4, consecutive cycles B may be valid-but-denied before it is forced a grant (1..15).

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- a_valid  input  1  requester A has a write
- a_reg  input  5  A destination register
- a_data  input  32  A write data
- a_ready  output  1  A write accepted this cycle when a_valid&&a_ready
- b_valid  input  1  requester B has a write
- b_reg  input  5  B destination register
- b_data  input  32  B write data
- b_ready  output  1  B write accepted this cycle when b_valid&&b_ready
- issue_valid  input  1  decode issues an instruction that will write issue_reg
- issue_reg  input  5  destination of issued instruction
- issue_ready  output  1  issue accepted (no outstanding write to same reg)
- rr1  input  5  decode read register 1
- rr2  input  5  decode read register 2
- hazard  output  1  rr1 or rr2 has an outstanding write; decode must stall
- pending  output  32  scoreboard bits, bit n = write to register n outstanding
- regWrite  output  1  register file write enable (registered)
- writeReg  output  5  register file write address (registered)
- writeData  output  32  register file write data (registered)

Behaviour:
- Reset: regWrite=0, writeReg=0, writeData=0, pending=0, starve counter=0. A write accepted in the cycle reset is high is discarded; reset wins over every simultaneous event.
- Grant rule (combinational): normally A has priority: a_ready=1, b_ready=!a_valid. When starve_cnt==STARVE_MAX and b_valid, B is forced: b_ready=1, a_ready=0 for that cycle.
- starve_cnt: increments (saturating at STARVE_MAX) each cycle b_valid&&!b_ready; clears to 0 on a B transfer or when b_valid=0.
- At most one transfer per cycle. The accepted write is registered: at the next edge, regWrite=1 and writeReg/writeData take the accepted reg/data. Latency is 1 cycle from accept to regWrite. With no transfer, regWrite=0 and writeReg/writeData hold.
- Register 0: the transfer is accepted normally but regWrite stays 0; pending[0] is never set.
- Scoreboard:
  - issue_ready = (issue_reg==0) || !pending[issue_reg]. This enforces WAW ordering.
  - On issue_valid&&issue_ready with issue_reg!=0, set pending[issue_reg] at the edge.
  - In any cycle with regWrite=1, clear pending[writeReg] at the edge. This coincides with the register file write.
  - If the same register is set and cleared at the same edge, set wins.
- hazard = (rr1!=0 && pending[rr1]) || (rr2!=0 && pending[rr2]). It stays asserted during the regWrite cycle and drops the cycle after, when the register file read returns new data.
- A requester writing a register with no pending bit is legal; the write proceeds with no scoreboard effect.
- Requesters must hold valid/reg/data stable until accepted (not checked).

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - Adds outputs fwd1 (1), fwd2 (1), fwd_data (32).
  - fwd1 = regWrite && writeReg==rr1 && rr1!=0; fwd2 likewise for rr2; fwd_data = writeData.
  - hazard excludes any register currently being forwarded, so a RAW stall ends one cycle earlier.
- Undefined: no extra ports; hazard exactly as specified above.

Test Plan:
- Reset mid-write: a_valid=1, a_reg=5, accepted, reset=1 the following cycle -> next cycle regWrite=0, pending=0, outputs 0.
- Single A write: issue r5, then a_valid=1, a_reg=5, a_data=0xDEADBEEF -> a_ready=1; next cycle regWrite=1, writeReg=5, writeData=0xDEADBEEF; pending[5] clears the cycle after; hazard with rr1=5 is 1 through the regWrite cycle and 0 afterwards.
- Contention/starvation, STARVE_MAX=4: a_valid and b_valid held continuously -> A granted 4 cycles, B granted on 5th (a_ready=0), then A again; the pattern repeats every 5 cycles.
- Register 0: a_valid=1, a_reg=0, a_data=0x1234 -> a_ready=1, regWrite stays 0, pending unchanged.
- WAW/simultaneous: pending[7]=1, issue_reg=7 -> issue_ready=0; in the regWrite cycle for r7, issue r7 -> issue_ready=0 that cycle, accepted the next cycle, pending[7]=1.
- WB_BYPASS_EN: regWrite=1, writeReg=3, writeData=0x55, rr2=3 -> fwd2=1, fwd_data=0x55, hazard=0. Without the macro, same stimulus -> hazard=1.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bus: two writeback requesters, decode issue/read ports,
// scoreboard view and the register file write port.
// Optional WB_BYPASS_EN adds the fwd1/fwd2/fwd_data forwarding outputs.
interface regfile_wb_arbiter_if;
  // Requester A (ALU)
  logic        a_valid;
  logic [4:0]  a_reg;
  logic [31:0] a_data;
  logic        a_ready;
  // Requester B (multi-cycle unit)
  logic        b_valid;
  logic [4:0]  b_reg;
  logic [31:0] b_data;
  logic        b_ready;
  // Decode issue and operand read registers
  logic        issue_valid;
  logic [4:0]  issue_reg;
  logic        issue_ready;
  logic [4:0]  rr1;
  logic [4:0]  rr2;
  logic        hazard;
  logic [31:0] pending;
  // Register file write port
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
`ifdef WB_BYPASS_EN
  logic        fwd1;
  logic        fwd2;
  logic [31:0] fwd_data;
`endif

  // Arbiter side
  modport slave (
    input  a_valid, a_reg, a_data,
    output a_ready,
    input  b_valid, b_reg, b_data,
    output b_ready,
    input  issue_valid, issue_reg,
    output issue_ready,
    input  rr1, rr2,
    output hazard, pending,
    output regWrite, writeReg, writeData
`ifdef WB_BYPASS_EN
    , output fwd1, fwd2, fwd_data
`endif
  );

  // Requester / decode / register file side
  modport master (
    output a_valid, a_reg, a_data,
    input  a_ready,
    output b_valid, b_reg, b_data,
    input  b_ready,
    output issue_valid, issue_reg,
    input  issue_ready,
    output rr1, rr2,
    input  hazard, pending,
    input  regWrite, writeReg, writeData
`ifdef WB_BYPASS_EN
    , input fwd1, fwd2, fwd_data
`endif
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter with a 32-entry pending-write scoreboard.
// A (ALU) has priority; B is forced through after STARVE_MAX denied cycles.
// Optional macro WB_BYPASS_EN: forward the register file write to decode
// (fwd1/fwd2/fwd_data) and drop forwarded registers from the hazard.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input logic                 clk,
  input logic                 reset,
  regfile_wb_arbiter_if.slave bus
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREG   = 32;

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0]  starve_cnt;
  logic [CNT_W-1:0]  starve_nxt;
  logic              force_b;
  logic              a_ready_c;
  logic              b_ready_c;
  logic              a_xfer;
  logic              b_xfer;
  logic [REG_W-1:0]  acc_reg;
  logic [DATA_W-1:0] acc_data;

  logic              reg_write_q;
  logic [REG_W-1:0]  write_reg_q;
  logic [DATA_W-1:0] write_data_q;

  logic [NREG-1:0]   pending_q;
  logic [NREG-1:0]   pending_nxt;
  logic              issue_ready_c;
  logic              hz1_c;
  logic              hz2_c;

  // Grant: A first unless B has waited STARVE_MAX cycles; pick accepted write
  always_comb begin
    force_b   = bus.b_valid && (starve_cnt == STARVE_LIM);
    a_ready_c = !force_b;
    b_ready_c = force_b || !bus.a_valid;
    a_xfer    = bus.a_valid && a_ready_c;
    b_xfer    = bus.b_valid && b_ready_c;
    acc_reg   = b_xfer ? bus.b_reg  : bus.a_reg;
    acc_data  = b_xfer ? bus.b_data : bus.a_data;
  end

  // Starvation counter: count denied B cycles, saturate, clear on grant or idle
  always_comb begin
    starve_nxt = starve_cnt;
    if (b_xfer || !bus.b_valid) begin
      starve_nxt = '0;
    end else if (starve_cnt < STARVE_LIM) begin
      starve_nxt = starve_cnt + CNT_W'(1);
    end
  end

  // Starvation counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_nxt;
    end
  end

  // Register the accepted write toward the register file; r0 never writes
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else if (a_xfer || b_xfer) begin
      reg_write_q  <= (acc_reg != REG_W'(0));
      write_reg_q  <= acc_reg;
      write_data_q <= acc_data;
    end else begin
      reg_write_q  <= 1'b0;
    end
  end

  // Issue is blocked while the destination still has a write outstanding
  always_comb begin
    issue_ready_c = (bus.issue_reg == REG_W'(0)) || !pending_q[bus.issue_reg];
  end

  // Scoreboard next state: clear on register file write, then set on issue
  always_comb begin
    pending_nxt = pending_q;
    if (reg_write_q) begin
      pending_nxt[write_reg_q] = 1'b0;
    end
    if (bus.issue_valid && issue_ready_c && (bus.issue_reg != REG_W'(0))) begin
      pending_nxt[bus.issue_reg] = 1'b1;
    end
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_nxt;
    end
  end

`ifdef WB_BYPASS_EN
  logic fwd1_c;
  logic fwd2_c;

  // Forward the in-flight register file write; forwarded operands do not stall
  always_comb begin
    fwd1_c = reg_write_q && (write_reg_q == bus.rr1) && (bus.rr1 != REG_W'(0));
    fwd2_c = reg_write_q && (write_reg_q == bus.rr2) && (bus.rr2 != REG_W'(0));
    hz1_c  = (bus.rr1 != REG_W'(0)) && pending_q[bus.rr1] && !fwd1_c;
    hz2_c  = (bus.rr2 != REG_W'(0)) && pending_q[bus.rr2] && !fwd2_c;
  end

  assign bus.fwd1     = fwd1_c;
  assign bus.fwd2     = fwd2_c;
  assign bus.fwd_data = write_data_q;
`else
  // RAW hazard on either read register with an outstanding write
  always_comb begin
    hz1_c = (bus.rr1 != REG_W'(0)) && pending_q[bus.rr1];
    hz2_c = (bus.rr2 != REG_W'(0)) && pending_q[bus.rr2];
  end
`endif

  assign bus.a_ready     = a_ready_c;
  assign bus.b_ready     = b_ready_c;
  assign bus.issue_ready = issue_ready_c;
  assign bus.hazard      = hz1_c || hz2_c;
  assign bus.pending     = pending_q;
  assign bus.regWrite    = reg_write_q;
  assign bus.writeReg    = write_reg_q;
  assign bus.writeData   = write_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized traffic, with a writeback scoreboard queue and a reference model.
module tb_regfile_wb_arbiter;

  localparam int unsigned SMAX = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if ifc();

  regfile_wb_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    int          c;
  } wb_t;

  wb_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit run   = 1'b0;

  // Reference model state
  bit [31:0]   m_pend;
  int unsigned m_wait;
  bit          m_wb;
  bit [4:0]    m_wreg;
  bit [31:0]   m_wdata;
  bit          last_a_x;
  bit          last_b_x;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every register file write must match the oldest expected write
  always @(negedge clk) begin
    if (run) begin
      if (ifc.regWrite === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wb_spurious: got write r%0d data %h want no write (cycle %0d)",
                   ifc.writeReg, ifc.writeData, cyc);
        end else begin
          wb_t e;
          e = exp_q.pop_front();
          chk32("wb_reg", 32'(ifc.writeReg), 32'(e.r));
          chk32("wb_data", ifc.writeData, e.d);
          chk32("wb_cycle", 32'(cyc), 32'(e.c));
        end
      end else if (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
        total++;
        bad++;
        $display("FAIL wb_missing: got no write want r%0d data %h (cycle %0d)",
                 exp_q[0].r, exp_q[0].d, cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  // Check combinational outputs against the model, then advance the model
  task automatic step();
    bit fb, er_a, er_b, er_iss, f1, f2, h1, h2, ax, bx;
    bit [4:0]  ar;
    bit [31:0] ad;
    fb     = ifc.b_valid && (m_wait == SMAX);
    er_a   = !fb;
    er_b   = fb || !ifc.a_valid;
    er_iss = (ifc.issue_reg == 5'd0) || !m_pend[ifc.issue_reg];
    f1     = m_wb && (m_wreg == ifc.rr1) && (ifc.rr1 != 5'd0);
    f2     = m_wb && (m_wreg == ifc.rr2) && (ifc.rr2 != 5'd0);
    h1     = (ifc.rr1 != 5'd0) && m_pend[ifc.rr1];
    h2     = (ifc.rr2 != 5'd0) && m_pend[ifc.rr2];
`ifdef WB_BYPASS_EN
    h1 = h1 && !f1;
    h2 = h2 && !f2;
    chk1("fwd1", ifc.fwd1, f1);
    chk1("fwd2", ifc.fwd2, f2);
    if (m_wb) chk32("fwd_data", ifc.fwd_data, m_wdata);
`endif
    chk1("a_ready", ifc.a_ready, er_a);
    chk1("b_ready", ifc.b_ready, er_b);
    chk1("issue_ready", ifc.issue_ready, er_iss);
    chk1("hazard", ifc.hazard, h1 || h2);
    chk32("pending", ifc.pending, m_pend);

    ax = ifc.a_valid && er_a;
    bx = ifc.b_valid && er_b;
    last_a_x = ax;
    last_b_x = bx;

    if (reset) begin
      m_pend  = '0;
      m_wait  = 0;
      m_wb    = 1'b0;
      m_wreg  = '0;
      m_wdata = '0;
    end else begin
      if (m_wb) m_pend[m_wreg] = 1'b0;
      if (ifc.issue_valid && er_iss && ifc.issue_reg != 5'd0) m_pend[ifc.issue_reg] = 1'b1;
      if (bx || !ifc.b_valid) m_wait = 0;
      else if (m_wait < SMAX) m_wait = m_wait + 1;
      if (ax || bx) begin
        ar = bx ? ifc.b_reg : ifc.a_reg;
        ad = bx ? ifc.b_data : ifc.a_data;
        m_wb    = (ar != 5'd0);
        m_wreg  = ar;
        m_wdata = ad;
        if (ar != 5'd0) exp_q.push_back('{r: ar, d: ad, c: cyc + 1});
      end else begin
        m_wb = 1'b0;
      end
    end
  endtask

  // Inputs are set at posedge+1; check mid-cycle, then move to the next posedge+1
  task automatic tick();
    #2;
    step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ifc.a_valid = 1'b0; ifc.a_reg = '0; ifc.a_data = '0;
    ifc.b_valid = 1'b0; ifc.b_reg = '0; ifc.b_data = '0;
    ifc.issue_valid = 1'b0; ifc.issue_reg = '0;
    ifc.rr1 = '0; ifc.rr2 = '0;
  endtask

  task automatic a_write(input logic [4:0] r, input logic [31:0] d);
    ifc.a_valid = 1'b1; ifc.a_reg = r; ifc.a_data = d;
  endtask

  initial begin
    bit [31:0] saved;
    reset = 1'b1;
    idle_in();
    m_pend = '0; m_wait = 0; m_wb = 1'b0; m_wreg = '0; m_wdata = '0;
    last_a_x = 1'b0; last_b_x = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_regWrite", ifc.regWrite, 1'b0);
    chk32("rst_writeReg", 32'(ifc.writeReg), 32'd0);
    chk32("rst_writeData", ifc.writeData, 32'd0);
    chk32("rst_pending", ifc.pending, 32'd0);
    reset = 1'b0;
    run = 1'b1;

    // Reset in the cycle after an accepted write
    ifc.issue_valid = 1'b1; ifc.issue_reg = 5'd9;
    tick();
    ifc.issue_reg = 5'd5;
    a_write(5'd5, 32'hA5A5_0001);
    tick();
    ifc.a_valid = 1'b0;
    ifc.issue_reg = 5'd12;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ifc.issue_valid = 1'b0;
    #1;
    chk1("mid_rst_regWrite", ifc.regWrite, 1'b0);
    chk32("mid_rst_pending", ifc.pending, 32'd0);
    chk32("mid_rst_writeReg", 32'(ifc.writeReg), 32'd0);
    chk32("mid_rst_writeData", ifc.writeData, 32'd0);
    tick();

    // Single A write with RAW hazard on r5
    ifc.issue_valid = 1'b1; ifc.issue_reg = 5'd5;
    tick();
    ifc.issue_valid = 1'b0;
    ifc.rr1 = 5'd5;
    a_write(5'd5, 32'hDEAD_BEEF);
    #1;
    chk1("single_a_ready", ifc.a_ready, 1'b1);
    chk1("single_hazard_pre", ifc.hazard, 1'b1);
    tick();
    ifc.a_valid = 1'b0;
    #1;
    chk1("single_regWrite", ifc.regWrite, 1'b1);
    chk32("single_writeReg", 32'(ifc.writeReg), 32'd5);
    chk32("single_writeData", ifc.writeData, 32'hDEAD_BEEF);
`ifdef WB_BYPASS_EN
    chk1("single_hazard_wb", ifc.hazard, 1'b0);
`else
    chk1("single_hazard_wb", ifc.hazard, 1'b1);
`endif
    tick();
    #1;
    chk1("single_hazard_post", ifc.hazard, 1'b0);
    chk1("single_pending5", ifc.pending[5], 1'b0);
    ifc.rr1 = 5'd0;
    tick();

    // Contention: A and B held valid; B forced every fifth cycle
    for (int i = 0; i < 10; i++) begin
      a_write(5'(16 + i % 4), $urandom);
      if (i == 0 || last_b_x) begin
        ifc.b_valid = 1'b1;
        ifc.b_reg   = 5'(20 + i % 3);
        ifc.b_data  = $urandom;
      end
      #1;
      chk1("contend_b_ready", ifc.b_ready, (i % 5) == 4);
      chk1("contend_a_ready", ifc.a_ready, (i % 5) != 4);
      tick();
    end
    idle_in();
    tick();
    tick();

    // Register 0 write: accepted, no register file write, scoreboard untouched
    saved = m_pend;
    a_write(5'd0, 32'h0000_1234);
    #1;
    chk1("r0_a_ready", ifc.a_ready, 1'b1);
    tick();
    ifc.a_valid = 1'b0;
    #1;
    chk1("r0_regWrite", ifc.regWrite, 1'b0);
    chk32("r0_pending", ifc.pending, saved);
    tick();

    // WAW: re-issue of r7 blocked until its write has reached the register file
    ifc.issue_valid = 1'b1; ifc.issue_reg = 5'd7;
    tick();
    #1;
    chk1("waw_blocked", ifc.issue_ready, 1'b0);
    tick();
    a_write(5'd7, 32'h0000_0077);
    tick();
    ifc.a_valid = 1'b0;
    #1;
    chk1("waw_regWrite", ifc.regWrite, 1'b1);
    chk32("waw_writeReg", 32'(ifc.writeReg), 32'd7);
    chk1("waw_blocked_wb", ifc.issue_ready, 1'b0);
    tick();
    #1;
    chk1("waw_accept", ifc.issue_ready, 1'b1);
    tick();
    ifc.issue_valid = 1'b0;
    #1;
    chk1("waw_pending7", ifc.pending[7], 1'b1);
    a_write(5'd7, 32'h0000_0777);
    tick();
    ifc.a_valid = 1'b0;
    tick();
    tick();

    // Forwarding case: r3 being written while decode reads it on rr2
    ifc.issue_valid = 1'b1; ifc.issue_reg = 5'd3;
    tick();
    ifc.issue_valid = 1'b0;
    a_write(5'd3, 32'h0000_0055);
    tick();
    ifc.a_valid = 1'b0;
    ifc.rr2 = 5'd3;
    #1;
    chk1("byp_regWrite", ifc.regWrite, 1'b1);
`ifdef WB_BYPASS_EN
    chk1("byp_fwd2", ifc.fwd2, 1'b1);
    chk32("byp_fwd_data", ifc.fwd_data, 32'h0000_0055);
    chk1("byp_hazard", ifc.hazard, 1'b0);
`else
    chk1("byp_hazard", ifc.hazard, 1'b1);
`endif
    tick();
    ifc.rr2 = 5'd0;
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(99) == 0);
      if (!ifc.a_valid || last_a_x) begin
        ifc.a_valid = ($urandom_range(2) != 0);
        ifc.a_reg   = 5'($urandom_range(7));
        ifc.a_data  = $urandom;
      end
      if (!ifc.b_valid || last_b_x) begin
        ifc.b_valid = ($urandom_range(1) != 0);
        ifc.b_reg   = 5'($urandom_range(7));
        ifc.b_data  = $urandom;
      end
      ifc.issue_valid = ($urandom_range(1) != 0);
      ifc.issue_reg   = 5'($urandom_range(7));
      ifc.rr1         = 5'($urandom_range(7));
      ifc.rr2         = 5'($urandom_range(7));
      tick();
    end

    reset = 1'b0;
    idle_in();
    repeat (3) tick();
    chk32("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
